// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: launch-FSM state encodings and
// default word/FIFO sizing.
package uart_pkg;

  localparam int DEF_DBIT   = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    TXF_IDLE  = 2'b00,
    TXF_START = 2'b01,
    TXF_WAIT  = 2'b10
  } txf_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO over a register array; r_data always shows the
// head entry so the consumer can register it in the same cycle it pops.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = DEF_DBIT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [DBIT-1:0]   w_data,
  output logic [DBIT-1:0]   r_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [DBIT-1:0]   mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_ok;
  logic              rd_ok;

  // A pop frees a slot in the same cycle, so a write at full is still taken.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= w_data;
  end

  assign r_data = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign full   = count_q[ADDR_W];
  assign empty  = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer and launch controller: pops one byte at a time into din,
// pulses tx_start for one cycle, then waits for the transmitter's done tick.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = DEF_DBIT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              tx_en,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy
);

  txf_state_e      state_q;
  logic            tx_start_q;
  logic [DBIT-1:0] din_q;
  logic [DBIT-1:0] fifo_r_data;
  logic            pop;

  // tx_en only gates new launches; a byte already in flight always finishes.
  assign pop = (state_q == TXF_IDLE) && tx_en && !empty;

  uart_fifo #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (pop),
    .w_data (w_data),
    .r_data (fifo_r_data),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TXF_IDLE;
      tx_start_q <= 1'b0;
      din_q      <= '0;
    end else begin
      case (state_q)
        TXF_IDLE: begin
          if (pop) begin
            din_q      <= fifo_r_data;
            tx_start_q <= 1'b1;
            state_q    <= TXF_START;
          end
        end
        TXF_START: begin
          tx_start_q <= 1'b0;
          state_q    <= TXF_WAIT;
        end
        TXF_WAIT: begin
          if (tx_done_tick) state_q <= TXF_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= TXF_IDLE;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign din      = din_q;
  assign busy     = (state_q != TXF_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue-based model checked every cycle,
// plus literal expectations for latency, ordering and flow control.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       tx_en;
  logic       tx_done_man;
  logic       tx_done_auto;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;

  assign tx_done_tick = tx_done_man | tx_done_auto;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .tx_en        (tx_en),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .din          (din),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .busy         (busy)
  );

  // Model: a byte queue of at most 16, a busy flag and the last launched byte.
  logic [7:0] mq[$];
  bit         m_busy;
  bit         m_start;
  logic [7:0] m_din;
  int         cyc;
  bit         launch;
  bit         done_ok;
  bit         space;

  initial begin
    m_busy  = 0;
    m_start = 0;
    m_din   = 8'h00;
    cyc     = 0;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      mq.delete();
      m_busy  = 0;
      m_start = 0;
      m_din   = 8'h00;
    end else begin
      launch  = !m_busy && tx_en && (mq.size() != 0);
      done_ok = m_busy && !m_start && tx_done_tick;
      space   = (mq.size() < 16) || launch;
      if (done_ok) m_busy = 0;
      if (launch) begin
        m_din  = mq.pop_front();
        m_busy = 1;
      end
      if (wr && space) mq.push_back(w_data);
      m_start = launch;
    end
  end

  // Transmitter stand-in: answers each tx_start with a done pulse done_delay cycles later.
  int done_delay = 5;
  int pend = 0;
  initial tx_done_auto = 1'b0;
  always @(negedge clk) begin
    tx_done_auto = 1'b0;
    if (reset) pend = 0;
    else if (tx_start) pend = done_delay;
    else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) tx_done_auto = 1'b1;
    end
  end

  int         total = 0;
  int         bad = 0;
  int         launches = 0;
  bit         saw_start;
  int         saw_cyc;
  logic [7:0] saw_din;
  logic [7:0] dut_log[$];

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // One cycle: compare everything at the falling edge, then re-enter the drive slot.
  task automatic step();
    @(negedge clk);
    chk("tx_start", int'(tx_start), int'(m_start));
    chk("din",      int'(din),      int'(m_din));
    chk("busy",     int'(busy),     int'(m_busy));
    chk("count",    int'(count),    mq.size());
    chk("full",     int'(full),     int'(mq.size() == 16));
    chk("empty",    int'(empty),    int'(mq.size() == 0));
    saw_start = tx_start;
    if (tx_start) begin
      saw_cyc  = cyc;
      saw_din  = din;
      launches = launches + 1;
      dut_log.push_back(din);
      $display("launch byte=0x%02h cycle=%0d count=%0d", din, cyc, count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (saw_start) return;
    end
    chk("wait_start_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy) return;
      step();
    end
    chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_drained(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (dut_log.size() >= n && !busy && empty) return;
      step();
    end
    chk("drain_timeout", 0, 1);
  endtask

  int k;
  int l0;

  initial begin
    reset = 1'b1; wr = 1'b0; w_data = 8'h00; tx_en = 1'b0; tx_done_man = 1'b0;
    #1;
    step(); step();
    reset = 1'b0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_busy", int'(busy), 0);

    // Done pulses while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      tx_done_man = 1'b1; step();
      tx_done_man = 1'b0; step();
    end
    chk("idle_done_busy", int'(busy), 0);

    // Single byte, two-cycle write-to-launch latency.
    done_delay = 6;
    tx_en = 1'b1; wr = 1'b1; w_data = 8'hA5; k = cyc;
    step();
    wr = 1'b0;
    wait_start(10);
    chk("single_latency", saw_cyc - k, 2);
    chk("single_din", int'(saw_din), 'hA5);
    chk("single_busy", int'(busy), 1);
    chk("single_pulse_len", int'(tx_start), 0);
    wait_idle(20);

    // Burst of 16 with launches held, then a dropped 17th write.
    tx_en = 1'b0;
    dut_log.delete();
    l0 = launches;
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(i); step();
    end
    w_data = 8'hFF; step();
    wr = 1'b0;
    chk("burst_count", int'(count), 16);
    chk("burst_full", int'(full), 1);
    done_delay = 20;
    tx_en = 1'b1;
    wait_drained(16, 600);
    chk("burst_pulses", launches - l0, 16);
    chk("burst_log_len", dut_log.size(), 16);
    for (int i = 0; i < 16 && i < dut_log.size(); i++)
      chk("burst_order", int'(dut_log[i]), i + 1);

    // Write coinciding with a pop while full is accepted.
    tx_en = 1'b0;
    dut_log.delete();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(8'h20 + i); step();
    end
    wr = 1'b0;
    chk("full_before", int'(count), 16);
    done_delay = 3;
    tx_en = 1'b1; wr = 1'b1; w_data = 8'h55;
    step();
    wr = 1'b0;
    chk("full_pop_write_count", int'(count), 16);
    wait_drained(17, 400);
    chk("full_log_len", dut_log.size(), 17);
    if (dut_log.size() == 17) begin
      chk("full_first", int'(dut_log[0]), 'h20);
      chk("full_17th", int'(dut_log[16]), 'h55);
    end

    // Flow control: dropping tx_en mid-frame lets the byte finish but holds the next.
    done_delay = 8;
    tx_en = 1'b1;
    wr = 1'b1; w_data = 8'hAA; step();
    w_data = 8'hBB; step();
    wr = 1'b0;
    wait_start(10);
    chk("fc_first", int'(saw_din), 'hAA);
    tx_en = 1'b0;
    wait_idle(30);
    l0 = launches;
    repeat (10) step();
    chk("fc_held", launches - l0, 0);
    chk("fc_count", int'(count), 1);
    tx_en = 1'b1; k = cyc;
    wait_start(10);
    chk("fc_resume_latency", saw_cyc - k, 1);
    chk("fc_second", int'(saw_din), 'hBB);
    wait_idle(30);

    // Reset while waiting with five bytes buffered.
    done_delay = 50;
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; w_data = 8'(8'h61 + i); step();
    end
    wr = 1'b0;
    step(); step();
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_empty", int'(empty), 1);
    dut_log.delete();
    done_delay = 4;
    wr = 1'b1; w_data = 8'h3C; step();
    wr = 1'b0;
    wait_start(10);
    chk("post_rst_din", int'(saw_din), 'h3C);
    wait_idle(20);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
